// File: rtl/lsu_bus_if.sv
// Simple req/ack data bus between the load/store unit and memory.
// The master drives a registered request; the slave answers with ack, read data and error.
interface lsu_bus_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ack, bus_rdata, bus_err
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ack, bus_rdata, bus_err
   );
endinterface

// File: rtl/lsu_unit.sv
// Load/store unit for the single-cycle core: one bus access per load/store instruction,
// stalling the PC until the access completes, faults, or times out.
module lsu_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata_o,
   output logic        fault,
   output logic [1:0]  fault_code,
   lsu_bus_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [1:0] CODE_NONE    = 2'b00;
   localparam logic [1:0] CODE_ILLEGAL = 2'b01;
   localparam logic [1:0] CODE_BUS     = 2'b10;
   localparam logic [1:0] CODE_TIMEOUT = 2'b11;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t           state, next_state;
   logic             op;
   logic             illegal;
   logic             timeout_hit;
   logic [3:0]       be_calc;
   logic [31:0]      wdata_calc;
   logic [31:0]      load_shift;
   logic [31:0]      load_ext;
   logic [2:0]       funct3_q;
   logic [1:0]       off_q;
   logic [1:0]       code_q;
   logic [CNT_W-1:0] cnt;

   assign op = mem_read | mem_write;

   // Access legality: funct3[1:0] is the size, funct3[2] the unsigned flag for loads.
   always_comb begin
      illegal = 1'b0;
      if (mem_read && mem_write) begin
         illegal = 1'b1;
      end else if (mem_read) begin
         if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end else if (mem_write) begin
         if (funct3[2] || funct3[1:0] == 2'b11) illegal = 1'b1;
      end
      if (funct3[1:0] == 2'b01 && addr[0])          illegal = 1'b1;
      if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) illegal = 1'b1;
   end

   // Lane steering for byte enables and replicated store data.
   always_comb begin
      be_calc    = 4'b1111;
      wdata_calc = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign load_shift = bus.bus_rdata >> {off_q, 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
         3'b100:  load_ext = {24'h0, load_shift[7:0]};
         3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
         3'b101:  load_ext = {16'h0, load_shift[15:0]};
         default: load_ext = bus.bus_rdata;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // NOTE: sequential state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      stall      = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (op) begin
               stall      = 1'b1;
               next_state = illegal ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            stall = 1'b1;
            if (bus.bus_ack || timeout_hit) next_state = S_RESP;
         end
         S_RESP: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign fault      = done && (code_q != CODE_NONE);
   assign fault_code = done ? code_q : CODE_NONE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= 32'h0;
         bus.bus_be    <= 4'h0;
         bus.bus_wdata <= 32'h0;
         rdata_o       <= 32'h0;
         funct3_q      <= 3'b000;
         off_q         <= 2'b00;
         code_q        <= CODE_NONE;
         cnt           <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (op) begin
                  if (illegal) begin
                     code_q <= CODE_ILLEGAL;
                  end else begin
                     bus.bus_req   <= 1'b1;
                     bus.bus_we    <= mem_write;
                     bus.bus_addr  <= {addr[31:2], 2'b00};
                     bus.bus_be    <= be_calc;
                     bus.bus_wdata <= wdata_calc;
                     funct3_q      <= funct3;
                     off_q         <= addr[1:0];
                     code_q        <= CODE_NONE;
                     cnt           <= '0;
                  end
               end
            end
            S_REQ: begin
               if (bus.bus_ack) begin
                  bus.bus_req <= 1'b0;
                  if (bus.bus_err) begin
                     code_q <= CODE_BUS;
                  end else if (!bus.bus_we) begin
                     rdata_o <= load_ext;
                  end
               end else if (timeout_hit) begin
                  bus.bus_req <= 1'b0;
                  code_q      <= CODE_TIMEOUT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: a behavioural bus slave answers requests after a
// programmed number of REQ cycles; expected results are queued at launch, popped at done.
module tb_lsu_unit;

   logic        clk;
   logic        rst_n;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] rdata_o;
   logic        fault;
   logic [1:0]  fault_code;

   lsu_bus_if bif ();

   lsu_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .wdata      (wdata),
      .stall      (stall),
      .done       (done),
      .rdata_o    (rdata_o),
      .fault      (fault),
      .fault_code (fault_code),
      .bus        (bif.master)
   );

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic [1:0]  code;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One access: drive it, play the bus slave, compare the popped expectation at done.
   task automatic run_op(input string name, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rdv, input logic err,
                         input int exp_stall, input int exp_reqs,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_code);
      exp_t e;
      exp_t got;
      int   stalls   = 0;
      int   reqs     = 0;
      bit   finished = 0;
      e.name  = name;
      e.rdata = exp_rdata;
      e.code  = exp_code;
      sb.push_back(e);
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      funct3    = f3;
      addr      = a;
      wdata     = wd;
      for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
         #1;
         if (stall) stalls++;
         bif.bus_ack   = 1'b0;
         bif.bus_err   = 1'b0;
         bif.bus_rdata = 32'h0;
         if (bif.bus_req) begin
            reqs++;
            if (reqs == 1) begin
               n_cmp++;
               if (bif.bus_addr !== exp_addr) begin
                  n_fail++;
                  $display("FAIL %s bus_addr: got %h want %h", name, bif.bus_addr, exp_addr);
               end
               n_cmp++;
               if (bif.bus_be !== exp_be) begin
                  n_fail++;
                  $display("FAIL %s bus_be: got %b want %b", name, bif.bus_be, exp_be);
               end
               n_cmp++;
               if (bif.bus_we !== wr) begin
                  n_fail++;
                  $display("FAIL %s bus_we: got %b want %b", name, bif.bus_we, wr);
               end
               if (wr) begin
                  n_cmp++;
                  if (bif.bus_wdata !== exp_wd) begin
                     n_fail++;
                     $display("FAIL %s bus_wdata: got %h want %h", name, bif.bus_wdata, exp_wd);
                  end
               end
            end
            if (reqs == ack_at) begin
               bif.bus_ack   = 1'b1;
               bif.bus_err   = err;
               bif.bus_rdata = rdv;
            end
         end
         if (done) begin
            finished = 1;
            got = sb.pop_front();
            n_cmp++;
            if (rdata_o !== got.rdata) begin
               n_fail++;
               $display("FAIL %s rdata_o: got %h want %h", got.name, rdata_o, got.rdata);
            end
            n_cmp++;
            if (fault_code !== got.code) begin
               n_fail++;
               $display("FAIL %s fault_code: got %b want %b", got.name, fault_code, got.code);
            end
            n_cmp++;
            if (fault !== (got.code != 2'b00)) begin
               n_fail++;
               $display("FAIL %s fault: got %b want %b", got.name, fault, got.code != 2'b00);
            end
         end else begin
            @(negedge clk);
         end
      end
      if (!finished) begin
         void'(sb.pop_front());
         n_cmp++;
         n_fail++;
         $display("FAIL %s done: never seen within 40 cycles", name);
      end else begin
         // Inputs are still asserted across the RESP edge: the unit must not relaunch.
         @(posedge clk);
         #1;
         n_cmp++;
         if (bif.bus_req !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s relaunch: got req=%b done=%b want 0/0", name, bif.bus_req, done);
         end
      end
      mem_read  = 1'b0;
      mem_write = 1'b0;
      n_cmp++;
      if (stalls !== exp_stall) begin
         n_fail++;
         $display("FAIL %s stall_cycles: got %0d want %0d", name, stalls, exp_stall);
      end
      n_cmp++;
      if (reqs !== exp_reqs) begin
         n_fail++;
         $display("FAIL %s req_cycles: got %0d want %0d", name, reqs, exp_reqs);
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      funct3        = 3'b000;
      addr          = 32'h0;
      wdata         = 32'h0;
      bif.bus_ack   = 1'b0;
      bif.bus_err   = 1'b0;
      bif.bus_rdata = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if ({stall, done, fault, fault_code} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: got stall=%b done=%b fault=%b code=%b want all 0",
                  stall, done, fault, fault_code);
      end
      n_cmp++;
      if (rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h want 00000000", rdata_o);
      end
      n_cmp++;
      if ({bif.bus_req, bif.bus_we, bif.bus_be} !== 6'b0 ||
          bif.bus_addr !== 32'h0 || bif.bus_wdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_bus: got req=%b we=%b be=%b addr=%h wdata=%h want all 0",
                  bif.bus_req, bif.bus_we, bif.bus_be, bif.bus_addr, bif.bus_wdata);
      end
   endtask

   task automatic test_loads();
      run_op("lw_100", 1, 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0,
             2, 1, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 2'b00);
      run_op("lb_203", 1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h80FF1234, 0,
             2, 1, 32'h200, 4'b1000, 32'h0, 32'hFFFFFF80, 2'b00);
      run_op("lbu_203", 1, 0, 3'b100, 32'h203, 32'h0, 1, 32'h80FF1234, 0,
             2, 1, 32'h200, 4'b1000, 32'h0, 32'h00000080, 2'b00);
      run_op("lh_202", 1, 0, 3'b001, 32'h202, 32'h0, 2, 32'h80FF1234, 0,
             3, 2, 32'h200, 4'b1100, 32'h0, 32'hFFFF80FF, 2'b00);
      run_op("lhu_200", 1, 0, 3'b101, 32'h200, 32'h0, 1, 32'h80FF9234, 0,
             2, 1, 32'h200, 4'b0011, 32'h0, 32'h00009234, 2'b00);
   endtask

   task automatic test_stores();
      run_op("sh_42", 0, 1, 3'b001, 32'h42, 32'h0000ABCD, 3, 32'h0, 0,
             4, 3, 32'h40, 4'b1100, 32'hABCDABCD, 32'h00009234, 2'b00);
      run_op("sb_41", 0, 1, 3'b000, 32'h41, 32'h12345678, 1, 32'h0, 0,
             2, 1, 32'h40, 4'b0010, 32'h78787878, 32'h00009234, 2'b00);
      run_op("sw_44", 0, 1, 3'b010, 32'h44, 32'h12345678, 1, 32'h0, 0,
             2, 1, 32'h44, 4'b1111, 32'h12345678, 32'h00009234, 2'b00);
   endtask

   task automatic test_illegal();
      run_op("lw_102", 1, 0, 3'b010, 32'h102, 32'h0, 1, 32'h0, 0,
             1, 0, 32'h0, 4'h0, 32'h0, 32'h00009234, 2'b01);
      run_op("lh_101", 1, 0, 3'b001, 32'h101, 32'h0, 1, 32'h0, 0,
             1, 0, 32'h0, 4'h0, 32'h0, 32'h00009234, 2'b01);
      run_op("rd_and_wr", 1, 1, 3'b010, 32'h100, 32'h0, 1, 32'h0, 0,
             1, 0, 32'h0, 4'h0, 32'h0, 32'h00009234, 2'b01);
      run_op("load_f3_011", 1, 0, 3'b011, 32'h100, 32'h0, 1, 32'h0, 0,
             1, 0, 32'h0, 4'h0, 32'h0, 32'h00009234, 2'b01);
      run_op("store_f3_100", 0, 1, 3'b100, 32'h100, 32'h0, 1, 32'h0, 0,
             1, 0, 32'h0, 4'h0, 32'h0, 32'h00009234, 2'b01);
   endtask

   task automatic test_faults();
      run_op("timeout", 1, 0, 3'b010, 32'h500, 32'h0, 0, 32'h0, 0,
             5, 4, 32'h500, 4'b1111, 32'h0, 32'h00009234, 2'b11);
      run_op("bus_err", 1, 0, 3'b010, 32'h504, 32'h0, 2, 32'h55555555, 1,
             3, 2, 32'h504, 4'b1111, 32'h0, 32'h00009234, 2'b10);
   endtask

   task automatic test_back_to_back();
      run_op("b2b_a", 1, 0, 3'b010, 32'h600, 32'h0, 1, 32'h01020304, 0,
             2, 1, 32'h600, 4'b1111, 32'h0, 32'h01020304, 2'b00);
      run_op("b2b_b", 1, 0, 3'b000, 32'h601, 32'h0, 1, 32'h01020304, 0,
             2, 1, 32'h600, 4'b0010, 32'h0, 32'h00000003, 2'b00);
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      mem_read = 1'b1;
      funct3   = 3'b010;
      addr     = 32'h300;
      @(negedge clk);
      #1;
      n_cmp++;
      if (bif.bus_req !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid pre_req: got %b want 1", bif.bus_req);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (bif.bus_req !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid drop: got req=%b done=%b want 0/0", bif.bus_req, done);
      end
      mem_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bif.bus_ack = 1'b0;
      #1;
      n_cmp++;
      if (done !== 1'b0 || bif.bus_req !== 1'b0 || stall !== 1'b0 || rdata_o !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid stray_ack: got done=%b req=%b stall=%b rdata=%h want 0/0/0/0",
                  done, bif.bus_req, stall, rdata_o);
      end
      run_op("after_rst", 1, 0, 3'b010, 32'h304, 32'h0, 1, 32'h0BADF00D, 0,
             2, 1, 32'h304, 4'b1111, 32'h0, 32'h0BADF00D, 2'b00);
   endtask

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_illegal();
      test_faults();
      test_back_to_back();
      test_reset_mid_access();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
